// File: rtl/regfile_loader.sv
// Sequential loader/dumper for the 32x32 register file: streams words into the write port
// and out of read port A. Optional running checksum under REGFILE_LOADER_CHECKSUM_EN.
module regfile_loader #(
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  RW,
    output logic [31:0] PW,
    output logic        LE,
    output logic [4:0]  RA,
    input  logic [31:0] PA,
    output logic [31:0] checksum
);

    localparam logic [4:0] FirstPtr = 5'(FIRST_REG);
    localparam logic [4:0] LastPtr  = 5'(LAST_REG);

    typedef enum logic [1:0] {StIdle, StLoad, StDump, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic        le_q, le_d;
    logic [4:0]  rw_q, rw_d;
    logic [31:0] pw_q, pw_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            le_q    <= 1'b0;
            rw_q    <= '0;
            pw_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            le_q    <= le_d;
            rw_q    <= rw_d;
            pw_q    <= pw_d;
        end
    end

    // Terminal test precedes the increment, so ptr never wraps.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        le_d    = 1'b0;
        rw_d    = rw_q;
        pw_d    = pw_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = mode ? StDump : StLoad;
                    ptr_d   = FirstPtr;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    le_d = 1'b1;
                    rw_d = ptr_q;
                    pw_d = in_data;
                    if (ptr_q == LastPtr) state_d = StDone;
                    else                  ptr_d   = ptr_q + 5'd1;
                end
            end
            StDump: begin
                if (out_ready) begin
                    if (ptr_q == LastPtr) state_d = StDone;
                    else                  ptr_d   = ptr_q + 5'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        in_ready  = (state_q == StLoad);
        out_valid = (state_q == StDump);
        RA        = ptr_q;
        out_data  = PA;
        RW        = rw_q;
        PW        = pw_q;
        LE        = le_q;
    end

`ifdef REGFILE_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
    logic        load_hs, dump_hs;

    always_comb begin
        load_hs = (state_q == StLoad) && in_valid;
        dump_hs = (state_q == StDump) && out_ready;
        csum_d  = csum_q;
        if (state_q == StIdle && start) csum_d = '0;
        else if (load_hs)               csum_d = csum_q + in_data;
        else if (dump_hs)               csum_d = csum_q + PA;
    end

    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// Directed self-checking bench: two loader instances (default range and 0..3), each with a
// behavioural register file hanging off its ports.
module tb_regfile_loader;

`ifdef REGFILE_LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, start2, mode, in_valid, in_valid2, out_ready;
    logic [31:0] in_data;

    logic        busy, done, in_ready, out_valid, le;
    logic [31:0] out_data, pw, pa, checksum;
    logic [4:0]  rw, ra;
    logic        busy2, done2, in_ready2, out_valid2, le2;
    logic [31:0] out_data2, pw2, pa2, checksum2;
    logic [4:0]  rw2, ra2;

    logic [31:0] rf  [32];
    logic [31:0] rf2 [32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_loader dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .RW(rw), .PW(pw), .LE(le), .RA(ra), .PA(pa), .checksum(checksum)
    );

    regfile_loader #(.FIRST_REG(0), .LAST_REG(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode), .busy(busy2), .done(done2),
        .in_data(in_data), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .RW(rw2), .PW(pw2), .LE(le2), .RA(ra2), .PA(pa2), .checksum(checksum2)
    );

    // R0 writes are dropped; R0 always reads 0.
    assign pa  = (ra == 5'd0)  ? 32'd0 : rf[ra];
    assign pa2 = (ra2 == 5'd0) ? 32'd0 : rf2[ra2];

    always @(posedge clk) begin
        if (le && rw != 5'd0)   rf[rw]   <= pw;
        if (le2 && rw2 != 5'd0) rf2[rw2] <= pw2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_sum;
        int          e;
        logic [3:0]  pat;
        logic [4:0]  exp_ptr;

        reset = 1'b1; start = 1'b0; start2 = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0; in_data = '0;
        step();
        step();
        reset = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_le", 32'(le), 32'd0);
        check_eq("rst_rw", 32'(rw), 32'd0);
        check_eq("rst_pw", pw, 32'd0);
        check_eq("rst_ra", 32'(ra), 32'd0);
        check_eq("rst_checksum", checksum, 32'd0);

        // Load, defaults, in_valid held high.
        start = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 32'h1000_0001;
        step();
        start = 1'b0;
        check_eq("load_busy_rise", 32'(busy), 32'd1);
        check_eq("load_in_ready", 32'(in_ready), 32'd1);
        exp_sum = '0;
        for (int i = 1; i <= 31; i++) begin
            step();
            exp_sum += 32'h1000_0000 + 32'(i);
            in_data = 32'h1000_0000 + 32'(i + 1);
            check_eq("load_le", 32'(le), 32'd1);
            check_eq("load_rw", 32'(rw), 32'(i));
            check_eq("load_pw", pw, 32'h1000_0000 + 32'(i));
            check_eq("load_done", 32'(done), (i == 31) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        check_eq("load_in_ready_done", 32'(in_ready), 32'd0);
        step();
        check_eq("load_done_clear", 32'(done), 32'd0);
        check_eq("load_busy_clear", 32'(busy), 32'd0);
        check_eq("load_checksum", checksum, ChkEn ? 32'hF000_01F0 : 32'd0);
        check_eq("load_r5", rf[5], 32'h1000_0005);

        // Dump with out_ready toggling 1,0,1,0.
        start = 1'b1; mode = 1'b1;
        step();
        start = 1'b0;
        e = 1;
        for (int c = 0; c < 61; c++) begin
            out_ready = (c % 2 == 0);
            check_eq("dump_valid", 32'(out_valid), 32'd1);
            check_eq("dump_data", out_data, 32'h1000_0000 + 32'(e));
            step();
            if (c % 2 == 0) e++;
        end
        out_ready = 1'b0;
        check_eq("dump_count", 32'(e), 32'd32);
        check_eq("dump_done", 32'(done), 32'd1);
        check_eq("dump_valid_off", 32'(out_valid), 32'd0);
        check_eq("dump_checksum", checksum, ChkEn ? 32'hF000_01F0 : 32'd0);
        step();

        // Range 0..3: load 0xAAAA_AAAA x4, dump, then back-to-back start.
        start2 = 1'b1; mode = 1'b0; in_valid2 = 1'b1; in_data = 32'hAAAA_AAAA;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("r03_le", 32'(le2), 32'd1);
            check_eq("r03_rw", 32'(rw2), 32'(i));
        end
        in_valid2 = 1'b0;
        check_eq("r03_load_done", 32'(done2), 32'd1);
        step();
        start2 = 1'b1; mode = 1'b1; out_ready = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("r03_dump", out_data2, (k == 0) ? 32'd0 : 32'hAAAA_AAAA);
            step();
        end
        out_ready = 1'b0;
        check_eq("r03_dump_done", 32'(done2), 32'd1);
        check_eq("r03_checksum", checksum2, ChkEn ? 32'hFFFF_FFFE : 32'd0);
        step();
        start2 = 1'b1; mode = 1'b0;
        check_eq("b2b_in_ready_pre", 32'(in_ready2), 32'd0);
        step();
        start2 = 1'b0;
        check_eq("b2b_in_ready", 32'(in_ready2), 32'd1);
        check_eq("b2b_checksum_clr", checksum2, 32'd0);

        // Gapped in_valid with start/mode wiggling during LOAD.
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        pat = 4'b1001;
        exp_ptr = 5'd1;
        for (int c = 0; c < 8; c++) begin
            in_valid = pat[c % 4];
            in_data = 32'h2000_0000 + 32'(c);
            start = (c == 1 || c == 2);
            mode = (c == 1 || c == 2);
            step();
            check_eq("gap_le", 32'(le), 32'(pat[c % 4]));
            if (pat[c % 4]) begin
                check_eq("gap_rw", 32'(rw), 32'(exp_ptr));
                check_eq("gap_pw", pw, 32'h2000_0000 + 32'(c));
                exp_ptr++;
            end
            check_eq("gap_mode_kept", 32'(in_ready), 32'd1);
            check_eq("gap_no_dump", 32'(out_valid), 32'd0);
        end
        start = 1'b0; mode = 1'b0; in_valid = 1'b0;

        // Reset after the 10th accepted word.
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1; in_valid = 1'b1; in_data = 32'h3000_0001;
        step();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            in_data = 32'h3000_0000 + 32'(i + 1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check_eq("mid_rst_le", 32'(le), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_r1", rf[1], 32'h3000_0001);
        check_eq("mid_rst_r10", rf[10], 32'h3000_000A);
        check_eq("mid_rst_r11", rf[11], 32'h1000_000B);
        for (int i = 0; i < 3; i++) begin
            check_eq("mid_rst_no_done", 32'(done), 32'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
